// File: rtl/noc_sink_arbiter_pkg.sv
// Shared types and helpers for the NoC sink arbiter.
package noc_arb_pkg;

   localparam int DEF_WIDTH = 57;
   localparam int DEF_CNT_W = 16;

   // Output stage occupancy.
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } ostate_e;

   // Index width for n sources; never narrower than one bit.
   function automatic int SRC_W(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/noc_sink_arbiter_if.sv
// Source-side and sink-side ready/valid bundle of the arbiter.
interface noc_sink_arbiter_if import noc_arb_pkg::*; #(
   parameter int NUM_SRC = 4,
   parameter int WIDTH   = DEF_WIDTH
) ();

   logic [NUM_SRC-1:0]         src_valid;
   logic [NUM_SRC*WIDTH-1:0]   src_data;
   logic [NUM_SRC-1:0]         src_ready;
   logic                       out_valid;
   logic [WIDTH-1:0]           out_data;
   logic [SRC_W(NUM_SRC)-1:0]  out_src;
   logic                       out_ready;

   // Environment side: generators plus the sink.
   modport master (
      output src_valid, src_data, out_ready,
      input  src_ready, out_valid, out_data, out_src
   );

   // Arbiter side.
   modport slave (
      input  src_valid, src_data, out_ready,
      output src_ready, out_valid, out_data, out_src
   );

endinterface

// File: rtl/noc_sink_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_pick #(
   parameter int N  = 4,
   parameter int SW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [SW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [SW-1:0] idx,
   output logic          any_req
);

   int   j;
   logic found;

   // Scan req cyclically starting at ptr; the first hit wins.
   always_comb begin
      gnt     = '0;
      idx     = '0;
      any_req = |req;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = SW'(j);
         end
      end
   end

endmodule

// File: rtl/noc_sink_arbiter.sv
// Round-robin arbiter sharing one registered output stage among NUM_SRC
// sources, with saturating per-source grant counters and an enabled-cycle count.
module noc_sink_arbiter import noc_arb_pkg::*; #(
   parameter int NUM_SRC = 4,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     enable,
   noc_sink_arbiter_if.slave        bus,
   output logic [NUM_SRC*CNT_W-1:0] grant_cnt,
   output logic [CNT_W-1:0]         cycle_cnt,
   output logic                     idle
);

   localparam int SW = SRC_W(NUM_SRC);

   ostate_e                         state_q, state_d;
   logic [WIDTH-1:0]                data_q, data_d;
   logic [SW-1:0]                   src_q, src_d;
   logic [SW-1:0]                   ptr_q, ptr_d;
   logic [NUM_SRC-1:0][CNT_W-1:0]   gcnt_q, gcnt_d;
   logic [CNT_W-1:0]                cyc_q, cyc_d;

   logic [NUM_SRC-1:0]              gnt;
   logic [SW-1:0]                   win;
   logic                            any_req;
   logic                            can_load, load, drain;

   rr_pick #(.N(NUM_SRC), .SW(SW)) u_pick (
      .req     (bus.src_valid),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .idx     (win),
      .any_req (any_req)
   );

   // Handshake: a load may overlap a drain on the same edge.
   always_comb begin
      can_load      = enable && ((state_q == EMPTY) || bus.out_ready);
      load          = can_load && any_req;
      drain         = (state_q == FULL) && bus.out_ready;
      bus.src_ready = (rst_n && load) ? gnt : '0;
      bus.out_valid = (state_q == FULL);
      bus.out_data  = data_q;
      bus.out_src   = src_q;
      idle          = (state_q == EMPTY) && !(|bus.src_valid);
      grant_cnt     = gcnt_q;
      cycle_cnt     = cyc_q;
   end

   // Next state of the output stage, pointer and counters.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      src_d   = src_q;
      ptr_d   = ptr_q;
      gcnt_d  = gcnt_q;
      cyc_d   = cyc_q;
      if (load) begin
         state_d = FULL;
         data_d  = bus.src_data[win*WIDTH +: WIDTH];
         src_d   = win;
         ptr_d   = (win == SW'(NUM_SRC-1)) ? '0 : win + SW'(1);
         if (gcnt_q[win] != '1) gcnt_d[win] = gcnt_q[win] + CNT_W'(1);
      end else if (drain) begin
         state_d = EMPTY;
      end
      if (enable && cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
   end

   // State register; reset discards any held beat.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         data_q  <= '0;
         src_q   <= '0;
         ptr_q   <= '0;
         gcnt_q  <= '0;
         cyc_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         src_q   <= src_d;
         ptr_q   <= ptr_d;
         gcnt_q  <= gcnt_d;
         cyc_q   <= cyc_d;
      end
   end

endmodule
